// File: rtl/fetch_unit.sv
// fetch_unit: PC holder fetching one word over req/ack and handing it to decode over valid/ready
`ifndef OPCODE_HCF
`define OPCODE_HCF 4'hF
`endif
module fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [3:0] HCF_OPCODE = `OPCODE_HCF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   halted,
  output logic [15:0]            fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] pc;
  assign imem_req = state == FETCH;
  assign instr_valid = state == HOLD;
  assign halted = state == HALT;
  assign imem_addr = pc;
  assign opcode = instr[INSTR_WIDTH-1 -: 4];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      instr_pc <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: state <= run ? FETCH : IDLE;
        FETCH: if (imem_ack) begin
          instr <= imem_rdata;
          instr_pc <= pc;
          pc <= pc + ADDR_WIDTH'(1);
          state <= HOLD;
        end
        HOLD: if (instr_ready) begin
          fetch_count <= fetch_count + 16'd1;
          state <= (opcode == HCF_OPCODE) ? HALT : run ? FETCH : IDLE;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit start, streaming, backpressure, wrap, halt and reset
module tb_fetch_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_rst_n, a_run, a_req, a_ack, a_valid, a_ready, a_halted, a_auto, a_force;
  logic [7:0] a_addr, a_pc;
  logic [15:0] a_rdata, a_instr, a_cnt;
  logic [3:0] a_op;
  logic [15:0] mem_a [256];
  logic b_rst_n, b_run, b_req, b_ack, b_valid, b_ready, b_halted, b_auto, b_force;
  logic [7:0] b_addr, b_pc;
  logic [15:0] b_rdata, b_instr, b_cnt;
  logic [3:0] b_op;
  logic [15:0] mem_b [256];
  assign a_ack = a_auto ? a_req : a_force;
  assign a_rdata = mem_a[a_addr];
  assign b_ack = b_auto ? b_req : b_force;
  assign b_rdata = mem_b[b_addr];
  fetch_unit u_a (
    .clk(clk), .rst_n(a_rst_n), .run(a_run), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(a_ack), .imem_rdata(a_rdata), .instr_valid(a_valid), .instr_ready(a_ready),
    .instr(a_instr), .opcode(a_op), .instr_pc(a_pc), .halted(a_halted), .fetch_count(a_cnt)
  );
  fetch_unit #(.RESET_PC(8'hFE)) u_b (
    .clk(clk), .rst_n(b_rst_n), .run(b_run), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata), .instr_valid(b_valid), .instr_ready(b_ready),
    .instr(b_instr), .opcode(b_op), .instr_pc(b_pc), .halted(b_halted), .fetch_count(b_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic req, input logic [7:0] addr,
                       input logic valid, input logic [15:0] ins, input logic [7:0] pc,
                       input logic [15:0] cnt);
    chk({tag, ".req"}, 32'(a_req), 32'(req));
    chk({tag, ".addr"}, 32'(a_addr), 32'(addr));
    chk({tag, ".valid"}, 32'(a_valid), 32'(valid));
    chk({tag, ".instr"}, 32'(a_instr), 32'(ins));
    chk({tag, ".pc"}, 32'(a_pc), 32'(pc));
    chk({tag, ".cnt"}, 32'(a_cnt), 32'(cnt));
    chk({tag, ".halted"}, 32'(a_halted), 32'(0));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[0] = 16'h1234; mem_a[1] = 16'h5678; mem_a[2] = 16'h9ABC;
    mem_a[3] = 16'h1111; mem_a[4] = 16'h2222;
    mem_b[8'hFE] = 16'h1001; mem_b[8'hFF] = 16'h2002; mem_b[8'h00] = 16'hF123;
    a_rst_n = 0; a_run = 0; a_ready = 1; a_auto = 1; a_force = 0;
    b_rst_n = 0; b_run = 0; b_ready = 1; b_auto = 1; b_force = 0;
    repeat (3) tick();
    a_rst_n = 1;
    tick();
    chk_a("rst0", 0, 8'h00, 0, 16'h0000, 8'h00, 16'd0);
    chk("rst0.op", 32'(a_op), 32'(0));
    tick();
    chk_a("rst1", 0, 8'h00, 0, 16'h0000, 8'h00, 16'd0);
    a_run = 1;
    tick();
    chk_a("start", 1, 8'h00, 0, 16'h0000, 8'h00, 16'd0);
    tick();
    chk_a("s0", 0, 8'h01, 1, 16'h1234, 8'h00, 16'd0);
    chk("s0.op", 32'(a_op), 32'h1);
    tick();
    chk_a("f1", 1, 8'h01, 0, 16'h1234, 8'h00, 16'd1);
    tick();
    chk_a("s1", 0, 8'h02, 1, 16'h5678, 8'h01, 16'd1);
    tick();
    chk_a("f2", 1, 8'h02, 0, 16'h5678, 8'h01, 16'd2);
    tick();
    chk_a("s2", 0, 8'h03, 1, 16'h9ABC, 8'h02, 16'd2);
    chk("s2.op", 32'(a_op), 32'h9);
    a_run = 0;
    tick();
    chk_a("idle3", 0, 8'h03, 0, 16'h9ABC, 8'h02, 16'd3);
    a_auto = 0; a_ready = 0; a_run = 1;
    tick();
    chk_a("w0", 1, 8'h03, 0, 16'h9ABC, 8'h02, 16'd3);
    a_run = 0;
    tick();
    chk_a("w1", 1, 8'h03, 0, 16'h9ABC, 8'h02, 16'd3);
    tick();
    chk_a("w2", 1, 8'h03, 0, 16'h9ABC, 8'h02, 16'd3);
    a_force = 1;
    tick();
    a_force = 0;
    chk_a("bp0", 0, 8'h04, 1, 16'h1111, 8'h03, 16'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("bp", 0, 8'h04, 1, 16'h1111, 8'h03, 16'd3);
    end
    a_ready = 1;
    tick();
    chk_a("bpdone", 0, 8'h04, 0, 16'h1111, 8'h03, 16'd4);
    a_ready = 0; a_run = 1;
    tick();
    chk_a("mf", 1, 8'h04, 0, 16'h1111, 8'h03, 16'd4);
    a_force = 1; a_rst_n = 0;
    tick();
    a_force = 0; a_rst_n = 1; a_run = 0;
    chk_a("mfrst", 0, 8'h00, 0, 16'h0000, 8'h00, 16'd0);
    tick();
    chk_a("mfidle", 0, 8'h00, 0, 16'h0000, 8'h00, 16'd0);
    b_rst_n = 1;
    tick();
    chk("b.rst.addr", 32'(b_addr), 32'hFE);
    chk("b.rst.req", 32'(b_req), 32'(0));
    b_run = 1;
    tick();
    chk("b.f0.req", 32'(b_req), 32'(1));
    chk("b.f0.addr", 32'(b_addr), 32'hFE);
    tick();
    chk("b.h0.valid", 32'(b_valid), 32'(1));
    chk("b.h0.pc", 32'(b_pc), 32'hFE);
    chk("b.h0.instr", 32'(b_instr), 32'h1001);
    tick();
    chk("b.f1.addr", 32'(b_addr), 32'hFF);
    chk("b.f1.req", 32'(b_req), 32'(1));
    tick();
    chk("b.h1.pc", 32'(b_pc), 32'hFF);
    chk("b.h1.instr", 32'(b_instr), 32'h2002);
    tick();
    chk("b.f2.addr", 32'(b_addr), 32'h00);
    tick();
    chk("b.h2.pc", 32'(b_pc), 32'h00);
    chk("b.h2.valid", 32'(b_valid), 32'(1));
    chk("b.h2.op", 32'(b_op), 32'hF);
    chk("b.h2.halted", 32'(b_halted), 32'(0));
    tick();
    chk("b.halt.halted", 32'(b_halted), 32'(1));
    chk("b.halt.valid", 32'(b_valid), 32'(0));
    chk("b.halt.cnt", 32'(b_cnt), 32'd3);
    b_auto = 0;
    for (int i = 0; i < 20; i++) begin
      b_force = i[0];
      tick();
      chk("b.stay.req", 32'(b_req), 32'(0));
      chk("b.stay.halted", 32'(b_halted), 32'(1));
      chk("b.stay.valid", 32'(b_valid), 32'(0));
    end
    chk("b.stay.cnt", 32'(b_cnt), 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MPS core, sitting directly upstream of the `Control` decoder. It holds the program counter, fetches one instruction word at a time from instruction memory over a req/ack handshake, and presents it to decode over a valid/ready handshake. It enters a terminal halted state after delivering the HCF instruction.

## Interface

Parameters:
- `ADDR_WIDTH`, 8: instruction memory address and PC width (word addressed).
- `INSTR_WIDTH`, 16: instruction word width; opcode is `instr[INSTR_WIDTH-1 -: 4]`.
- `RESET_PC`, 0: PC value loaded on reset.
- `HCF_OPCODE`, `` `OPCODE_HCF `` (config.inc.v): opcode that halts fetch.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `run` in 1: fetch enable; sampled only in IDLE and at decode handoff.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out ADDR_WIDTH: fetch address; equals current PC.
- `imem_ack` in 1: memory response; `imem_rdata` valid in the same cycle.
- `imem_rdata` in INSTR_WIDTH: fetched instruction word.
- `instr_valid` out 1: `instr`/`opcode`/`instr_pc` valid for decode.
- `instr_ready` in 1: decode accepts the instruction this cycle.
- `instr` out INSTR_WIDTH: registered instruction word.
- `opcode` out 4: `instr` top nibble; feeds `Control.opcode`.
- `instr_pc` out ADDR_WIDTH: address the held instruction came from.
- `halted` out 1: high once HCF has been handed to decode.
- `fetch_count` out 16: instructions delivered to decode since reset.

## Operation

- Four states: IDLE, FETCH, HOLD, HALT. Reset puts the block in IDLE.
- IDLE: `imem_req`=0. If `run`=1, go to FETCH next cycle.
- FETCH: `imem_req`=1 and `imem_addr`=PC, held stable until `imem_ack`. On ack, register `imem_rdata` into `instr` and PC into `instr_pc`. PC becomes PC+1, mod 2^ADDR_WIDTH, so 8'hFF wraps to 8'h00. Go to HOLD.
- HOLD: `instr_valid`=1 and `imem_req`=0. `instr`, `opcode` and `instr_pc` stay stable until the handshake `instr_valid && instr_ready`. On handshake, `fetch_count` increments (wraps at 16 bits), then:
  - if `opcode`==HCF_OPCODE, go to HALT;
  - else if `run`=1, go to FETCH;
  - else go to IDLE.
- HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. `run` and `imem_ack` are ignored. Only reset exits HALT.
- `imem_ack` is ignored in any state other than FETCH.
- `run` dropping during FETCH or HOLD does not abort the in-flight fetch or the pending delivery.
- Outputs `imem_req`, `instr_valid` and `halted` are decoded from the registered state only, with no combinational path from any input.

## Timing

- Reset values: state IDLE, PC=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `opcode`=0, `instr_pc`=0, `halted`=0, `fetch_count`=0.
- Reset dominates every other event in the same cycle.
- Reset during FETCH drops `imem_req` in the next cycle. An ack arriving in that reset cycle is discarded.
- Latency:
  - `run` high in IDLE at cycle N gives `imem_req` at N+1.
  - `imem_ack` at cycle M gives `instr_valid` at M+1.
  - Handshake at cycle K with `run`=1 gives the next `imem_req` at K+1.
- Peak throughput is one instruction per 2 cycles, reached with zero-wait memory and `instr_ready` tied high.
- `halted` rises the cycle after the HCF handshake and `instr_valid` falls in that same cycle.

## Test plan

- Reset/start: hold `rst_n`=0 for 3 cycles, then release with `run`=0. All outputs stay at reset values. Raise `run`: `imem_req`=1 with `imem_addr`=0x00 exactly one cycle later.
- Zero-wait stream: memory acks in the request cycle and returns 16'h1234, 16'h5678, 16'h9ABC; `instr_ready`=1. Instructions appear at 2-cycle spacing with `instr_pc` 0, 1, 2; `fetch_count`=3.
- Backpressure and wait states: memory acks 3 cycles after req; `instr_ready` held low 4 cycles. `imem_addr` stays stable while waiting for ack, `instr` stays stable under backpressure, and no second `imem_req` is issued before the handshake.
- Wrap: RESET_PC=8'hFE, three fetches. `instr_pc` sequence FE, FF, 00.
- HCF: third word has opcode HCF_OPCODE. It is delivered with `instr_valid`=1, `halted`=1 the next cycle, and no further `imem_req` over 20 cycles with `run`=1 and spurious `imem_ack` pulses.
- Reset mid-fetch: assert `rst_n`=0 during FETCH in the same cycle as `imem_ack`. Next cycle: state IDLE, `instr_valid`=0, PC=RESET_PC, `fetch_count`=0.
